// File: rtl/dsp48_slice.sv
// Behavioural DSP48 slice: 18x18 signed multiplier into a 48-bit X/Y/Z add/subtract unit.
// Define DSP48_SLICE_PARAM_CHECK_EN for elaboration-time parameter checks and illegal-OPMODE warnings.
module dsp48_slice #(
    parameter int unsigned AREG          = 1,
    parameter int unsigned BREG          = 1,
    parameter int unsigned CREG          = 1,
    parameter int unsigned MREG          = 1,
    parameter int unsigned PREG          = 1,
    parameter int unsigned CARRYINREG    = 1,
    parameter int unsigned CARRYINSELREG = 1,
    parameter int unsigned OPMODEREG     = 1,
    parameter int unsigned SUBTRACTREG   = 1,
    parameter string       B_INPUT       = "DIRECT",
    parameter string       LEGACY_MODE   = "NONE"
) (
    input  logic        CLK,
    input  logic        RSTA,
    input  logic        RSTB,
    input  logic        RSTC,
    input  logic        RSTM,
    input  logic        RSTP,
    input  logic        RSTCARRYIN,
    input  logic        RSTCTRL,
    input  logic        CEA,
    input  logic        CEB,
    input  logic        CEC,
    input  logic        CEM,
    input  logic        CEP,
    input  logic        CECARRYIN,
    input  logic        CECINSUB,
    input  logic        CECTRL,
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] BCIN,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic        CARRYIN,
    input  logic [6:0]  OPMODE,
    input  logic        SUBTRACT,
    input  logic [1:0]  CARRYINSEL,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic [17:0] BCOUT
);

    logic        unused_cfg;
    assign unused_cfg = (LEGACY_MODE == "NONE");

    logic [17:0] b_sel;
    assign b_sel = (B_INPUT == "CASCADE") ? BCIN : B;

    // A/B pipelines: both stages share CE and reset, depth picks the tap.
    logic [17:0] a1_q, a2_q, b1_q, b2_q, a_q, b_q;
    always_ff @(posedge CLK) begin
        if (RSTA) begin
            a1_q <= '0;
            a2_q <= '0;
        end else if (CEA) begin
            a1_q <= A;
            a2_q <= a1_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTB) begin
            b1_q <= '0;
            b2_q <= '0;
        end else if (CEB) begin
            b1_q <= b_sel;
            b2_q <= b1_q;
        end
    end

    assign a_q   = (AREG == 0) ? A     : (AREG == 1) ? a1_q : a2_q;
    assign b_q   = (BREG == 0) ? b_sel : (BREG == 1) ? b1_q : b2_q;
    assign BCOUT = b_q;

    logic [47:0] c_q, c_val;
    always_ff @(posedge CLK) begin
        if (RSTC)     c_q <= '0;
        else if (CEC) c_q <= C;
    end
    assign c_val = (CREG == 0) ? C : c_q;

    logic [6:0] opmode_q, opmode_val;
    logic [1:0] carryinsel_q, carryinsel_val;
    logic       subtract_q, subtract_val;
    logic       carryin_q, carryin_val;
    logic       xnor_q, xnor_comb;

    always_ff @(posedge CLK) begin
        if (RSTCTRL) begin
            opmode_q     <= '0;
            carryinsel_q <= '0;
        end else if (CECTRL) begin
            opmode_q     <= OPMODE;
            carryinsel_q <= CARRYINSEL;
        end
    end

    always_ff @(posedge CLK) begin
        if (RSTCTRL)       subtract_q <= 1'b0;
        else if (CECINSUB) subtract_q <= SUBTRACT;
    end

    always_ff @(posedge CLK) begin
        if (RSTCARRYIN)    carryin_q <= 1'b0;
        else if (CECINSUB) carryin_q <= CARRYIN;
    end

    // Sign-agreement carry, registered copy lines up with MREG=1.
    assign xnor_comb = ~(a_q[17] ^ b_q[17]);
    always_ff @(posedge CLK) begin
        if (RSTCARRYIN)     xnor_q <= 1'b0;
        else if (CECARRYIN) xnor_q <= xnor_comb;
    end

    assign opmode_val     = (OPMODEREG == 0)     ? OPMODE     : opmode_q;
    assign carryinsel_val = (CARRYINSELREG == 0) ? CARRYINSEL : carryinsel_q;
    assign subtract_val   = (SUBTRACTREG == 0)   ? SUBTRACT   : subtract_q;
    assign carryin_val    = (CARRYINREG == 0)    ? CARRYIN    : carryin_q;

    logic signed [35:0] m_comb;
    logic        [35:0] m_q, m_val;
    assign m_comb = $signed(a_q) * $signed(b_q);
    always_ff @(posedge CLK) begin
        if (RSTM)     m_q <= '0;
        else if (CEM) m_q <= m_comb;
    end
    assign m_val = (MREG == 0) ? m_comb : m_q;

    logic [47:0] m_ext, ab_ext, p_q;
    assign m_ext  = {{12{m_val[35]}}, m_val};
    assign ab_ext = {{12{a_q[17]}}, a_q, b_q};

    // Feedback always taps the P register so PREG=0 never forms a combinational loop.
    logic [47:0] x_mux, y_mux, z_mux, sum;
    logic        cin;
    always_comb begin
        x_mux = '0;
        case (opmode_val[1:0])
            2'b01:   x_mux = m_ext;
            2'b10:   x_mux = p_q;
            2'b11:   x_mux = ab_ext;
            default: x_mux = '0;
        endcase

        // Y=01 is the other half of the M pair already carried by X.
        y_mux = (opmode_val[3:2] == 2'b11) ? c_val : '0;

        z_mux = '0;
        case (opmode_val[6:4])
            3'b001:  z_mux = PCIN;
            3'b010:  z_mux = p_q;
            3'b011:  z_mux = c_val;
            3'b101:  z_mux = {{17{PCIN[47]}}, PCIN[47:17]};
            3'b110:  z_mux = {{17{p_q[47]}}, p_q[47:17]};
            default: z_mux = '0;
        endcase

        cin = 1'b0;
        case (carryinsel_val)
            2'b00: cin = carryin_val;
            2'b01: cin = (opmode_val[6:4] == 3'b010 || opmode_val[6:4] == 3'b110) ?
                         ~p_q[47] : ~PCIN[47];
            2'b10: cin = xnor_comb;
            2'b11: cin = xnor_q;
            default: cin = 1'b0;
        endcase

        if (subtract_val) sum = z_mux - (x_mux + y_mux + {47'd0, cin});
        else              sum = z_mux + x_mux + y_mux + {47'd0, cin};
    end

    always_ff @(posedge CLK) begin
        if (RSTP)     p_q <= '0;
        else if (CEP) p_q <= sum;
    end

    assign P     = (PREG == 0) ? sum : p_q;
    assign PCOUT = P;

`ifdef DSP48_SLICE_PARAM_CHECK_EN
    localparam bit RegsOk = (AREG <= 2) && (BREG <= 2) && (CREG <= 1) && (MREG <= 1) &&
                            (PREG <= 1) && (CARRYINREG <= 1) && (CARRYINSELREG <= 1) &&
                            (OPMODEREG <= 1) && (SUBTRACTREG <= 1);
    localparam bit BInputOk = (B_INPUT == "DIRECT") || (B_INPUT == "CASCADE");
    localparam bit LegacyOk = (LEGACY_MODE == "NONE") || (LEGACY_MODE == "MULT18X18") ||
                              (LEGACY_MODE == "MULT18X18S");

    if (!RegsOk) begin : g_err_regs
        $error("dsp48_slice: register parameter out of range");
    end
    if (!BInputOk) begin : g_err_binput
        $error("dsp48_slice: unknown B_INPUT");
    end
    if (!LegacyOk) begin : g_err_legacy
        $error("dsp48_slice: unknown LEGACY_MODE");
    end

    logic opmode_bad;
    assign opmode_bad = ((opmode_val[1:0] == 2'b01) != (opmode_val[3:2] == 2'b01)) ||
                        (opmode_val[3:2] == 2'b10) ||
                        (opmode_val[6:4] == 3'b100) || (opmode_val[6:4] == 3'b111);

    always @(posedge CLK) begin
        if (opmode_bad) $warning("dsp48_slice: illegal OPMODE %b", opmode_val);
    end
`endif

endmodule

// File: tb/tb_dsp48_slice.sv
// Directed bench: an all-combinational slice and an all-registered cascade-B slice.
module tb_dsp48_slice;

    logic        CLK = 1'b0;
    logic        RSTA, RSTB, RSTC, RSTM, RSTP, RSTCARRYIN, RSTCTRL;
    logic        CEA, CEB, CEC, CEM, CEP, CECARRYIN, CECINSUB, CECTRL;
    logic [17:0] A, B, BCIN;
    logic [47:0] C, PCIN;
    logic        CARRYIN, SUBTRACT;
    logic [6:0]  OPMODE;
    logic [1:0]  CARRYINSEL;
    logic [47:0] p_c, pcout_c, p_r, pcout_r;
    logic [17:0] bcout_c, bcout_r;

    int n_pass  = 0;
    int n_total = 0;
    logic signed [47:0] exp_p;
    logic        [17:0] exp_b;

    always #5 CLK = ~CLK;

    dsp48_slice #(
        .AREG(0), .BREG(0), .CREG(0), .MREG(0), .PREG(0), .CARRYINREG(0),
        .CARRYINSELREG(0), .OPMODEREG(0), .SUBTRACTREG(0),
        .B_INPUT("DIRECT"), .LEGACY_MODE("NONE")
    ) u_comb (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTM(RSTM), .RSTP(RSTP),
        .RSTCARRYIN(RSTCARRYIN), .RSTCTRL(RSTCTRL), .CEA(CEA), .CEB(CEB), .CEC(CEC),
        .CEM(CEM), .CEP(CEP), .CECARRYIN(CECARRYIN), .CECINSUB(CECINSUB), .CECTRL(CECTRL),
        .A(A), .B(B), .BCIN(BCIN), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .SUBTRACT(SUBTRACT), .CARRYINSEL(CARRYINSEL), .P(p_c), .PCOUT(pcout_c),
        .BCOUT(bcout_c)
    );

    dsp48_slice #(
        .AREG(1), .BREG(1), .CREG(1), .MREG(1), .PREG(1), .CARRYINREG(1),
        .CARRYINSELREG(1), .OPMODEREG(1), .SUBTRACTREG(1),
        .B_INPUT("CASCADE"), .LEGACY_MODE("NONE")
    ) u_reg (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTM(RSTM), .RSTP(RSTP),
        .RSTCARRYIN(RSTCARRYIN), .RSTCTRL(RSTCTRL), .CEA(CEA), .CEB(CEB), .CEC(CEC),
        .CEM(CEM), .CEP(CEP), .CECARRYIN(CECARRYIN), .CECINSUB(CECINSUB), .CECTRL(CECTRL),
        .A(A), .B(B), .BCIN(BCIN), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN), .OPMODE(OPMODE),
        .SUBTRACT(SUBTRACT), .CARRYINSEL(CARRYINSEL), .P(p_r), .PCOUT(pcout_r),
        .BCOUT(bcout_r)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rst(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTM = v; RSTP = v; RSTCARRYIN = v; RSTCTRL = v;
    endtask

    task automatic test_reset();
        set_rst(1'b1);
        CEA = 1; CEB = 1; CEC = 1; CEM = 1; CEP = 1; CECARRYIN = 1; CECINSUB = 1; CECTRL = 1;
        A = 18'd5; B = 18'd5; BCIN = 18'd9; C = 48'd77; PCIN = 48'd0;
        CARRYIN = 1; SUBTRACT = 0; OPMODE = 7'b0110101; CARRYINSEL = 2'b00;
        tick();
        n_total++;
        if (p_r !== 48'd0 || pcout_r !== 48'd0)
            $display("FAIL reset_p: P=%0d PCOUT=%0d expected 0", p_r, pcout_r);
        else n_pass++;
        n_total++;
        if (bcout_r !== 18'd0) $display("FAIL reset_bcout: got %0d expected 0", bcout_r);
        else n_pass++;
        set_rst(1'b0);
    endtask

    task automatic test_comb_mult();
        A = 18'd3; B = -18'sd5; OPMODE = 7'b0000101; SUBTRACT = 0;
        CARRYINSEL = 2'b00; CARRYIN = 0;
        #1;
        exp_p = -15; exp_b = -18'sd5;
        n_total++;
        if (p_c !== exp_p || pcout_c !== exp_p)
            $display("FAIL comb_mult: P=%0d PCOUT=%0d expected %0d",
                     $signed(p_c), $signed(pcout_c), exp_p);
        else n_pass++;
        n_total++;
        if (bcout_c !== exp_b) $display("FAIL comb_bcout: got %h expected %h", bcout_c, exp_b);
        else n_pass++;
        CARRYIN = 1; #1;
        exp_p = -14;
        n_total++;
        if (p_c !== exp_p) $display("FAIL comb_carryin: P=%0d expected %0d", $signed(p_c), exp_p);
        else n_pass++;
        CARRYIN = 0; CARRYINSEL = 2'b10; #1;
        exp_p = -15;
        n_total++;
        if (p_c !== exp_p) $display("FAIL comb_xnor0: P=%0d expected %0d", $signed(p_c), exp_p);
        else n_pass++;
        A = -18'sd3; #1;
        exp_p = 16;
        n_total++;
        if (p_c !== exp_p) $display("FAIL comb_xnor1: P=%0d expected %0d", $signed(p_c), exp_p);
        else n_pass++;
        CARRYINSEL = 2'b00; A = 18'h20000; B = 18'h20000; #1;
        exp_p = 48'sd17179869184;
        n_total++;
        if (p_c !== exp_p) $display("FAIL comb_minmin: P=%0d expected %0d", $signed(p_c), exp_p);
        else n_pass++;
    endtask

    task automatic test_concat();
        OPMODE = 7'b0000011; A = 18'd1; B = 18'd0; #1;
        exp_p = 262144;
        n_total++;
        if (p_c !== exp_p) $display("FAIL concat_pos: P=%0d expected %0d", $signed(p_c), exp_p);
        else n_pass++;
        A = 18'h3ffff; #1;
        exp_p = -262144;
        n_total++;
        if (p_c !== exp_p) $display("FAIL concat_neg: P=%0d expected %0d", $signed(p_c), exp_p);
        else n_pass++;
    endtask

    task automatic test_subtract();
        SUBTRACT = 1; OPMODE = 7'b0110011; C = 48'd1000; A = 18'd0; B = 18'd10; #1;
        exp_p = 990;
        n_total++;
        if (p_c !== exp_p) $display("FAIL sub_c_ab: P=%0d expected %0d", $signed(p_c), exp_p);
        else n_pass++;
        OPMODE = 7'b1010101; PCIN = 48'd1048576; #1;
        exp_p = 8;
        n_total++;
        if (p_c !== exp_p) $display("FAIL sub_pcin_shift: P=%0d expected %0d", $signed(p_c), exp_p);
        else n_pass++;
        SUBTRACT = 0; PCIN = 48'd0;
    endtask

    task automatic test_cascade_pipe();
        A = 18'd6; BCIN = 18'd7; B = 18'd1; C = 48'd100; OPMODE = 7'b0110101;
        CARRYIN = 0; CARRYINSEL = 2'b00; SUBTRACT = 0;
        set_rst(1'b1); tick(); set_rst(1'b0);
        tick();
        n_total++;
        if (bcout_r !== 18'd7) $display("FAIL pipe_bcout: got %0d expected 7", bcout_r);
        else n_pass++;
        tick();
        n_total++;
        if (p_r !== 48'd100) $display("FAIL pipe_edge2: P=%0d expected 100", $signed(p_r));
        else n_pass++;
        tick();
        n_total++;
        if (p_r !== 48'd142 || pcout_r !== 48'd142)
            $display("FAIL pipe_edge3: P=%0d PCOUT=%0d expected 142", p_r, pcout_r);
        else n_pass++;
    endtask

    task automatic test_accumulate();
        A = 18'd2; BCIN = 18'd3; OPMODE = 7'b0100101; CARRYIN = 1; CARRYINSEL = 2'b00;
        RSTP = 1; tick(); tick(); tick(); RSTP = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_total++;
            if (p_r !== 48'(7 * i)) $display("FAIL accum_%0d: P=%0d expected %0d", i, p_r, 7 * i);
            else n_pass++;
        end
    endtask

    task automatic test_stage_resets();
        A = 18'd6; BCIN = 18'd7; C = 48'd100; OPMODE = 7'b0110101; CARRYIN = 0;
        tick(); tick(); tick();
        n_total++;
        if (p_r !== 48'd142) $display("FAIL rst_base: P=%0d expected 142", p_r);
        else n_pass++;

        RSTC = 1; tick(); RSTC = 0; tick();
        n_total++;
        if (p_r !== 48'd42) $display("FAIL rstc_only: P=%0d expected 42", p_r);
        else n_pass++;
        tick();

        RSTM = 1; tick(); RSTM = 0; tick();
        n_total++;
        if (p_r !== 48'd100) $display("FAIL rstm_only: P=%0d expected 100", p_r);
        else n_pass++;
        tick();

        RSTA = 1; tick(); RSTA = 0;
        n_total++;
        if (bcout_r !== 18'd7) $display("FAIL rsta_keeps_b: BCOUT=%0d expected 7", bcout_r);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (p_r !== 48'd100) $display("FAIL rsta_only: P=%0d expected 100", p_r);
        else n_pass++;
        tick();

        RSTB = 1; tick(); RSTB = 0;
        n_total++;
        if (bcout_r !== 18'd0) $display("FAIL rstb_only: BCOUT=%0d expected 0", bcout_r);
        else n_pass++;
        tick(); tick(); tick();
        n_total++;
        if (p_r !== 48'd142) $display("FAIL rstb_recover: P=%0d expected 142", p_r);
        else n_pass++;

        RSTCTRL = 1; tick(); RSTCTRL = 0; tick();
        n_total++;
        if (p_r !== 48'd0) $display("FAIL rstctrl_only: P=%0d expected 0", p_r);
        else n_pass++;
        tick();

        CEP = 0; RSTP = 1; tick(); RSTP = 0;
        n_total++;
        if (p_r !== 48'd0 || pcout_r !== 48'd0)
            $display("FAIL rstp_no_cep: P=%0d PCOUT=%0d expected 0", p_r, pcout_r);
        else n_pass++;
        tick();
        n_total++;
        if (p_r !== 48'd0) $display("FAIL cep_hold: P=%0d expected 0", p_r);
        else n_pass++;
        CEP = 1; tick();
        n_total++;
        if (p_r !== 48'd142) $display("FAIL cep_resume: P=%0d expected 142", p_r);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_comb_mult();
        test_concat();
        test_subtract();
        test_cascade_pipe();
        test_accumulate();
        test_stage_resets();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
